// File: rtl/mem_scan_pkg.sv
// Shared types and default widths for the memory sweep engine.
// Pure declarations: no logic, no latency, no flow control.
// The optional max-value datapath is selected with MEM_SCANNER_MAX_EN.
package mem_scan_pkg;

    localparam int MS_AW   = 8;
    localparam int MS_DW   = 16;
    localparam int MS_ACCW = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mem_scan_accum.sv
// Sum / key-match / max accumulators for one scan, optional max under MEM_SCANNER_MAX_EN.
// Latency: one word folded in per enabled clock; results visible the cycle after the edge.
// Backpressure: none; the caller gates with en_i, clr_i wins over en_i.
module mem_scan_accum
    import mem_scan_pkg::*;
#(
    parameter int AW   = MS_AW,
    parameter int DW   = MS_DW,
    parameter int ACCW = MS_ACCW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [DW-1:0]   data_i,
    input  logic [DW-1:0]   key_i,
`ifdef MEM_SCANNER_MAX_EN
    output logic [DW-1:0]   max_val_o,
`endif
    output logic [ACCW-1:0] sum_o,
    output logic [AW:0]     match_count_o
);

    logic [ACCW-1:0] sum_q, sum_d;
    logic [AW:0]     cnt_q, cnt_d;

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (en_i) begin
            // Words are unsigned; the sum wraps modulo 2^ACCW.
            sum_d = sum_q + {{(ACCW-DW){1'b0}}, data_i};
            cnt_d = cnt_q + {{AW{1'b0}}, (data_i == key_i)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign sum_o         = sum_q;
    assign match_count_o = cnt_q;

`ifdef MEM_SCANNER_MAX_EN
    logic [DW-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (clr_i) begin
            max_d = '0;
        end else if (en_i && (data_i > max_q)) begin
            max_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_val_o = max_q;
`endif

endmodule

// File: rtl/mem_scanner.sv
// Sweeps len words from base through Memory, reporting sum, key matches (and max with MEM_SCANNER_MAX_EN).
// Latency: one word per clock; done pulses len+1 cycles after the accepted start edge.
// Backpressure: none; start is ignored while busy, Memory is assumed to answer every read.
module mem_scanner
    import mem_scan_pkg::*;
#(
    parameter int AW   = MS_AW,
    parameter int DW   = MS_DW,
    parameter int ACCW = MS_ACCW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW-1:0]   base,
    input  logic [AW:0]     len,
    input  logic [DW-1:0]   key,
    output logic [AW-1:0]   Address,
    output logic            re,
    output logic            we,
    input  logic [DW-1:0]   Data,
    output logic            busy,
    output logic            done,
`ifdef MEM_SCANNER_MAX_EN
    output logic [DW-1:0]   max_val,
`endif
    output logic [ACCW-1:0] sum,
    output logic [AW:0]     match_count
);

    scan_state_t   state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [DW-1:0] key_q, key_d;
    logic          accept;

    assign accept = (state_q == IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (rem_q == {{AW{1'b0}}, 1'b1}) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        re      = 1'b0;
        Address = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            READ: begin
                re      = 1'b1;
                Address = ptr_q;
                busy    = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign we = 1'b0;

    // Pointer is AW bits wide, so base+k wraps through 0 with no extra logic.
    always_comb begin
        ptr_d = ptr_q;
        rem_d = rem_q;
        key_d = key_q;
        if (accept) begin
            ptr_d = base;
            rem_d = len;
            key_d = key;
        end else if (state_q == READ) begin
            ptr_d = ptr_q + 1'b1;
            rem_d = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            rem_q <= '0;
            key_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
            key_q <= key_d;
        end
    end

    mem_scan_accum #(
        .AW   (AW),
        .DW   (DW),
        .ACCW (ACCW)
    ) u_accum (
        .clk           (clk),
        .reset         (reset),
        .clr_i         (accept),
        .en_i          (state_q == READ),
        .data_i        (Data),
        .key_i         (key_q),
`ifdef MEM_SCANNER_MAX_EN
        .max_val_o     (max_val),
`endif
        .sum_o         (sum),
        .match_count_o (match_count)
    );

endmodule
